parking_occupancy_counter: RTL
==============================

Name: parking_occupancy_counter

Overview:
- Sits directly downstream of the two-sensor gate direction FSM and consumes its `enter` and `exit` outputs.
- Those outputs are Mealy, combinational from asynchronous sensors, and can stay high for several cycles.
- This block registers and edge-detects them, keeps a saturating count of occupied spaces up to CAPACITY, and drives the full/empty status, free-space count, "spaces available" sign and sticky over/underflow fault flags.
- A lot-status FSM (OPEN / FULL / FAULT) supervises the count. Maintenance staff can force the count through a load port.

Parameters:
- CAPACITY, 10, number of spaces in the lot; must satisfy 1 <= CAPACITY <= 2^CNT_W - 1.
- CNT_W, 4, width of the count and free-space buses.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- enter  in  1  car-entered indication from the gate FSM; level, may be held for multiple cycles.
- exit  in  1  car-exited indication from the gate FSM; level, may be held for multiple cycles.
- load  in  1  synchronous count preset strobe.
- load_val  in  CNT_W  preset value; clamped to CAPACITY.
- err_clr  in  1  clears the sticky fault flags and leaves FAULT.
- count  out  CNT_W  occupied spaces (registered).
- free  out  CNT_W  CAPACITY - count (registered, always consistent with count).
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- avail  out  1  sign lamp; 1 only in state OPEN.
- ovf_err  out  1  sticky: enter event seen while full.
- unf_err  out  1  sticky: exit event seen while empty.

Behaviour:
- Reset (rst_n low, async):
  - count=0, free=CAPACITY, empty=1, full=0, avail=1, ovf_err=0, unf_err=0.
  - State OPEN; edge-detect registers cleared.
- Input stage:
  - enter_r/exit_r sample enter/exit each edge; enter_r2/exit_r2 delay them by one more cycle.
  - ent_ev = enter_r & ~enter_r2; ext_ev = exit_r & ~exit_r2.
  - One event per high level regardless of its length. A level that goes high, low, high gives two events.
- Latency: enter high first sampled at edge N produces the count update at edge N+1. count, free, full, empty and avail are all registered and update together.
- Count update at each edge, in priority order:
  - load=1: count <= min(load_val, CAPACITY). Events in the same cycle are discarded and flags are unaffected.
  - ent_ev & ext_ev: count unchanged, no error, including when full or empty.
  - ent_ev only:
    - count < CAPACITY: count+1.
    - Else: count holds at CAPACITY and ovf_err <= 1.
  - ext_ev only:
    - count > 0: count-1.
    - Else: count holds at 0 and unf_err <= 1.
  - No wrap-around, ever.
- Sticky flags:
  - Cleared only by err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the flag is set (the error wins).
- Lot FSM (next state computed from the next count and next flags):
  - OPEN:
    - Go to FAULT if either flag is set.
    - Else go to FULL if next count == CAPACITY.
    - Else stay in OPEN.
  - FULL:
    - Go to FAULT if either flag is set.
    - Else go to OPEN if next count < CAPACITY.
    - Else stay in FULL.
  - FAULT:
    - Stay while either flag is set; counting continues (saturating).
    - When err_clr clears both flags with no new error, go to FULL if count == CAPACITY, else OPEN.
  - avail = (state == OPEN).
- Load behaviour: load while in FAULT does not clear the flags.
- Mid-operation reset: an async assert immediately returns every output to its reset value. An event pending in the edge registers is lost.

Test Plan:
- Reset, then enter held high for 5 cycles -> exactly one increment: count=1, free=9, empty=0, avail=1; count changes one edge after enter is first sampled.
- 10 separated enter pulses (CAPACITY=10) -> count=10, full=1, avail=0, state FULL; an 11th pulse -> count stays 10, ovf_err=1, state FAULT; err_clr -> ovf_err=0, state FULL.
- From count=0, one exit pulse -> count=0, unf_err=1, avail=0; then an enter pulse -> count=1, still FAULT; err_clr -> OPEN, avail=1.
- enter and exit rising on the same edge at count=10 -> count=10, no flag set; same test at count=0 -> count=0, no flag set.
- load=1 with load_val=15 -> count=10, full=1; load=1 with load_val=3 concurrent with an enter edge -> count=3 and the event is ignored.
- rst_n pulsed low mid-count (count=6) between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter with edge-detected enter/exit events,
// saturating count, sticky fault flags and an OPEN/FULL/FAULT lot FSM.
module parking_occupancy_counter #(
    parameter int CAPACITY = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic             exit,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             avail,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        S_OPEN  = 2'd0,
        S_FULL  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             enter_r;
    logic             enter_r2;
    logic             exit_r;
    logic             exit_r2;
    logic             ent_ev;
    logic             ext_ev;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_n;
    logic             unf_n;

    assign ent_ev = enter_r & ~enter_r2;
    assign ext_ev = exit_r & ~exit_r2;

    // Register and delay the gate levels so each high level yields one event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_r  <= 1'b0;
            enter_r2 <= 1'b0;
            exit_r   <= 1'b0;
            exit_r2  <= 1'b0;
        end else begin
            enter_r  <= enter;
            enter_r2 <= enter_r;
            exit_r   <= exit;
            exit_r2  <= exit_r;
        end
    end

    // Next count: load preset wins, simultaneous events cancel, saturate at ends
    always_comb begin
        cnt_n   = count;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (load) begin
            cnt_n = (load_val > CAP) ? CAP : load_val;
        end else if (ent_ev && !ext_ev) begin
            if (count < CAP) cnt_n = count + 1'b1;
            else             ovf_set = 1'b1;
        end else if (ext_ev && !ent_ev) begin
            if (count != '0) cnt_n = count - 1'b1;
            else             unf_set = 1'b1;
        end
    end

    assign ovf_n = ovf_set | (ovf_err & ~err_clr);
    assign unf_n = unf_set | (unf_err & ~err_clr);

    // Count, derived status and sticky flags all update on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            free    <= CAP;
            full    <= 1'b0;
            empty   <= 1'b1;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            count   <= cnt_n;
            free    <= CAP - cnt_n;
            full    <= (cnt_n == CAP);
            empty   <= (cnt_n == '0);
            ovf_err <= ovf_n;
            unf_err <= unf_n;
        end
    end

    // Lot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_OPEN;
        else        state <= state_n;
    end

    // Lot next state from the upcoming count and flags
    always_comb begin
        state_n = state;
        unique case (state)
            S_OPEN: begin
                if (ovf_n || unf_n)    state_n = S_FAULT;
                else if (cnt_n == CAP) state_n = S_FULL;
                else                   state_n = S_OPEN;
            end
            S_FULL: begin
                if (ovf_n || unf_n)   state_n = S_FAULT;
                else if (cnt_n < CAP) state_n = S_OPEN;
                else                  state_n = S_FULL;
            end
            S_FAULT: begin
                if (ovf_n || unf_n)     state_n = S_FAULT;
                else if (cnt_n == CAP)  state_n = S_FULL;
                else                    state_n = S_OPEN;
            end
            default: state_n = S_OPEN;
        endcase
    end

    // Sign lamp lit only while the lot is open
    always_comb begin
        avail = (state == S_OPEN);
    end

endmodule
